// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: supervises SB_PLL40 lock and generates the system reset.
// Holds the PLL in reset, waits for lock, debounces it and then releases sys_resetn.
// A lock timeout or a lost lock re-resets the PLL, with a bounded number of retries.
// Runs entirely on the 12 MHz reference clock.
// Optional feature macro: PLL_LOCK_STATS_EN. When it is defined, the saturating
// lock-loss counter is implemented. When it is undefined, lock_loss_cnt reads 0.
module pll_lock_sequencer #(
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 12000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clk_12mhz,
    input  logic       resetn,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       sys_resetn,
    output logic       fail,
    output logic [2:0] state,
    output logic [3:0] retries,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned MAX_A   = (PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      PLL_RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_P   = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int unsigned TIMER_W = $clog2(MAX_P) + 1;

    typedef enum logic [2:0] {
        ST_PLLRST    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [3:0]           retries_q, retries_d;
    logic [3:0]           retries_inc;
    logic                 pll_resetb_q, pll_resetb_d;
    logic                 sys_resetn_q, sys_resetn_d;
    logic                 fail_q, fail_d;
    logic [1:0]           sync_q;
    logic                 lk;
    logic                 loss_evt_c;

    // Two-flop synchroniser for the asynchronous PLL lock output
    always_ff @(posedge clk_12mhz or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign lk          = sync_q[1];
    assign retries_inc = retries_q + 4'd1;
    assign loss_evt_c  = (state_q == ST_RUN) && !lk;

    // State, timer, retry counter and registered outputs
    always_ff @(posedge clk_12mhz or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_PLLRST;
            timer_q      <= '0;
            retries_q    <= 4'd0;
            pll_resetb_q <= 1'b0;
            sys_resetn_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retries_q    <= retries_d;
            pll_resetb_q <= pll_resetb_d;
            sys_resetn_q <= sys_resetn_d;
            fail_q       <= fail_d;
        end
    end

    // Next-state, timer and output decode; restart overrides every transition
    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        timer_d   = timer_q;

        unique case (state_q)
            ST_PLLRST: begin
                // lk deliberately ignored while the PLL is held in reset
                if (timer_q == TIMER_W'(PLL_RESET_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk) begin
                    state_d = ST_STABLE;
                end else if (timer_q == TIMER_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    retries_d = retries_inc;
                    state_d   = (retries_inc == 4'(MAX_RETRIES)) ? ST_FAIL : ST_PLLRST;
                end
            end
            ST_STABLE: begin
                if (!lk) begin
                    state_d = ST_WAIT_LOCK;
                end else if (timer_q == TIMER_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d   = ST_RUN;
                    retries_d = 4'd0;
                end
            end
            ST_RUN: begin
                if (!lk) begin
                    state_d = ST_PLLRST;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PLLRST;
            end
        endcase

        if (restart) begin
            state_d   = ST_PLLRST;
            retries_d = 4'd0;
        end

        // Timer restarts on every state entry and only runs in timed states
        if (restart || (state_d != state_q)) begin
            timer_d = '0;
        end else if ((state_q == ST_PLLRST) || (state_q == ST_WAIT_LOCK) ||
                     (state_q == ST_STABLE)) begin
            timer_d = timer_q + TIMER_W'(1);
        end

        pll_resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                       (state_d == ST_RUN);
        sys_resetn_d = (state_d == ST_RUN);
        fail_d       = (state_d == ST_FAIL);
    end

`ifdef PLL_LOCK_STATS_EN
    logic [7:0] lock_loss_q, lock_loss_d;

    // Saturating count of lock losses seen while running
    always_comb begin
        lock_loss_d = lock_loss_q;
        if (loss_evt_c && (lock_loss_q != 8'hFF)) begin
            lock_loss_d = lock_loss_q + 8'd1;
        end
    end

    // Lock-loss counter register
    always_ff @(posedge clk_12mhz or negedge resetn) begin
        if (!resetn) begin
            lock_loss_q <= 8'd0;
        end else begin
            lock_loss_q <= lock_loss_d;
        end
    end

    assign lock_loss_cnt = lock_loss_q;
`else
    logic unused_loss;
    assign unused_loss   = loss_evt_c;
    assign lock_loss_cnt = 8'd0;
`endif

    assign state      = state_q;
    assign retries    = retries_q;
    assign pll_resetb = pll_resetb_q;
    assign sys_resetn = sys_resetn_q;
    assign fail       = fail_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: table-driven checks of the PLL lock sequencer with a
// small expectation queue, plus hand-written lock-loss saturation and async-reset sequences.
module tb_pll_lock_sequencer;

`ifdef PLL_LOCK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk;
    logic       resetn;
    logic       pll_locked;
    logic       restart;
    logic       pll_resetb;
    logic       sys_resetn;
    logic       fail;
    logic [2:0] state;
    logic [3:0] retries;
    logic [7:0] lock_loss_cnt;

    pll_lock_sequencer #(
        .PLL_RESET_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .clk_12mhz    (clk),
        .resetn       (resetn),
        .pll_locked   (pll_locked),
        .restart      (restart),
        .pll_resetb   (pll_resetb),
        .sys_resetn   (sys_resetn),
        .fail         (fail),
        .state        (state),
        .retries      (retries),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       do_rst;
        int       edge_n;
        bit       lk_in;
        bit       rs_in;
        bit       pb;
        bit       sr;
        bit       f;
        int       st;
        int       rt;
        int       ll;
    } vec_t;

    typedef struct {
        logic       pb;
        logic       sr;
        logic       f;
        logic [2:0] st;
        logic [3:0] rt;
        logic [7:0] ll;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cur_edge = 0;

    task automatic add(bit r, int e, bit l, bit s, bit pb, bit sr, bit f, int st, int rt, int ll);
        vec_t v;
        v.do_rst = r; v.edge_n = e; v.lk_in = l; v.rs_in = s;
        v.pb = pb; v.sr = sr; v.f = f; v.st = st; v.rt = rt; v.ll = ll;
        tbl.push_back(v);
    endtask

    task automatic sb_push(bit pb, bit sr, bit f, int st, int rt, int ll);
        exp_t e;
        e.pb = pb; e.sr = sr; e.f = f;
        e.st = 3'(st); e.rt = 4'(rt);
        e.ll = STATS ? 8'(ll) : 8'd0;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(string nm);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: no expectation queued", nm);
        end else begin
            e = sb_q.pop_front();
            if ({pll_resetb, sys_resetn, fail, state, retries, lock_loss_cnt} !==
                {e.pb, e.sr, e.f, e.st, e.rt, e.ll}) begin
                n_errors++;
                $display("FAIL %s: got pb=%0b sr=%0b f=%0b st=%0d rt=%0d ll=%0d, want pb=%0b sr=%0b f=%0b st=%0d rt=%0d ll=%0d",
                         nm, pll_resetb, sys_resetn, fail, state, retries, lock_loss_cnt,
                         e.pb, e.sr, e.f, e.st, e.rt, e.ll);
            end
        end
    endtask

    // Async reset mid-cycle, check immediately, release just after edge 0
    task automatic do_reset(string nm);
        @(posedge clk);
        #1;
        resetn = 1'b0; pll_locked = 1'b0; restart = 1'b0;
        #1;
        sb_push(0, 0, 0, 0, 0, 0);
        sb_check(nm);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn   = 1'b1;
        cur_edge = 0;
    endtask

    task automatic wait_sysr(logic val, int budget, output int edges, output bit ok);
        edges = 0;
        while ((sys_resetn !== val) && (edges < budget)) begin
            @(posedge clk);
            #1;
            edges++;
        end
        ok = (sys_resetn === val);
    endtask

    initial begin
        int  edges;
        bit  ok;
        resetn = 1'b0; pll_locked = 1'b0; restart = 1'b0;

        // Power-up, lock at edge 10, release at 21; then lock loss in RUN and relock
        add(1,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0,   3, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0,   4, 0, 0, 1, 0, 0, 1, 0, 0);
        add(0,  10, 1, 0, 1, 0, 0, 1, 0, 0);
        add(0,  12, 1, 0, 1, 0, 0, 1, 0, 0);
        add(0,  13, 1, 0, 1, 0, 0, 2, 0, 0);
        add(0,  20, 1, 0, 1, 0, 0, 2, 0, 0);
        add(0,  21, 1, 0, 1, 1, 0, 3, 0, 0);
        add(0,  30, 0, 0, 1, 1, 0, 3, 0, 0);
        add(0,  32, 0, 0, 1, 1, 0, 3, 0, 0);
        add(0,  33, 1, 0, 0, 0, 0, 0, 0, 1);
        add(0,  36, 1, 0, 0, 0, 0, 0, 0, 1);
        add(0,  37, 1, 0, 1, 0, 0, 1, 0, 1);
        add(0,  38, 1, 0, 1, 0, 0, 2, 0, 1);
        add(0,  45, 1, 0, 1, 0, 0, 2, 0, 1);
        add(0,  46, 1, 0, 1, 1, 0, 3, 0, 1);
        // No lock: two timeouts into FAIL, restart from FAIL, restart from RUN
        add(1,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0,  23, 0, 0, 1, 0, 0, 1, 0, 0);
        add(0,  24, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0,  27, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0,  28, 0, 0, 1, 0, 0, 1, 1, 0);
        add(0,  47, 0, 0, 1, 0, 0, 1, 1, 0);
        add(0,  48, 0, 0, 0, 0, 1, 4, 2, 0);
        add(0,  60, 1, 0, 0, 0, 1, 4, 2, 0);
        add(0, 160, 1, 1, 0, 0, 1, 4, 2, 0);
        add(0, 161, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 164, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 165, 1, 0, 1, 0, 0, 1, 0, 0);
        add(0, 166, 1, 0, 1, 0, 0, 2, 0, 0);
        add(0, 173, 1, 0, 1, 0, 0, 2, 0, 0);
        add(0, 174, 1, 0, 1, 1, 0, 3, 0, 0);
        add(0, 180, 1, 1, 1, 1, 0, 3, 0, 0);
        add(0, 181, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 186, 1, 0, 1, 0, 0, 2, 0, 0);
        add(0, 194, 1, 0, 1, 1, 0, 3, 0, 0);
        add(0, 199, 0, 0, 1, 1, 0, 3, 0, 0);
        add(0, 201, 0, 1, 1, 1, 0, 3, 0, 0);
        add(0, 202, 0, 0, 0, 0, 0, 0, 0, 1);
        // One timeout, then a lock glitch in STABLE, then a clean lock to RUN
        add(1,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0,  24, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0,  28, 1, 0, 1, 0, 0, 1, 1, 0);
        add(0,  30, 1, 0, 1, 0, 0, 1, 1, 0);
        add(0,  31, 1, 0, 1, 0, 0, 2, 1, 0);
        add(0,  33, 0, 0, 1, 0, 0, 2, 1, 0);
        add(0,  35, 0, 0, 1, 0, 0, 2, 1, 0);
        add(0,  36, 0, 0, 1, 0, 0, 1, 1, 0);
        add(0,  38, 1, 0, 1, 0, 0, 1, 1, 0);
        add(0,  40, 1, 0, 1, 0, 0, 1, 1, 0);
        add(0,  41, 1, 0, 1, 0, 0, 2, 1, 0);
        add(0,  48, 1, 0, 1, 0, 0, 2, 1, 0);
        add(0,  49, 1, 0, 1, 1, 0, 3, 0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) begin
                do_reset($sformatf("async_reset_v%0d", i));
            end
            sb_push(tbl[i].pb, tbl[i].sr, tbl[i].f, tbl[i].st, tbl[i].rt, tbl[i].ll);
            while (cur_edge < tbl[i].edge_n) begin
                @(posedge clk);
                #1;
                cur_edge++;
            end
            sb_check($sformatf("vec%0d_edge%0d", i, tbl[i].edge_n));
            pll_locked = tbl[i].lk_in;
            restart    = tbl[i].rs_in;
        end

        // 256 RUN lock losses: latency bound and counter saturation
        do_reset("async_reset_sat");
        pll_locked = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            wait_sysr(1'b1, 60, edges, ok);
            if (!ok) begin
                n_checks++; n_errors++;
                $display("FAIL sat_run_%0d: sys_resetn=%0b after %0d edges, want 1", i, sys_resetn, edges);
                break;
            end
            pll_locked = 1'b0;
            wait_sysr(1'b0, 3, edges, ok);
            if ((i == 1) || !ok) begin
                n_checks++;
                if (!ok) begin
                    n_errors++;
                    $display("FAIL loss_latency_%0d: sys_resetn=%0b after %0d edges, want 0 within 3", i, sys_resetn, edges);
                    break;
                end
            end
            pll_locked = 1'b1;
            if ((i == 1) || (i == 254) || (i == 255) || (i == 256)) begin
                sb_push(0, 0, 0, 0, 0, (i > 255) ? 255 : i);
                sb_check($sformatf("lock_loss_%0d", i));
            end
        end

        // Async reset while in STABLE returns everything to reset values at once
        edges = 0;
        while ((state !== 3'd2) && (edges < 30)) begin
            @(posedge clk);
            #1;
            edges++;
        end
        sb_push(1, 0, 0, 2, 0, 255);
        sb_check("reach_stable");
        #3;
        resetn = 1'b0;
        #1;
        sb_push(0, 0, 0, 0, 0, 0);
        sb_check("reset_mid_stable");
        #20;
        resetn = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
